// File: rtl/sys_feeder_pkg.sv
// Shared types and constants for the 2x2 systolic-array feeder.
package sys_feeder_pkg;

  localparam int SYS_COLS = 2;
  localparam logic [15:0] UB_COL_SIZE = 16'd2;

  typedef logic signed [15:0] fixed16_t;
  typedef fixed16_t [SYS_COLS-1:0] vector16_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W_CAP  = 3'd1,
    ST_PUSH0  = 3'd2,
    ST_PUSH1  = 3'd3,
    ST_STREAM = 3'd4,
    ST_DRAIN  = 3'd5
  } sys_feeder_state_t;

endpackage

// File: rtl/sys_feeder_skew.sv
// One-stage data+valid delay; data is forced to zero when the input is not valid.
module sys_skew_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              vld_out,
  output logic [DATA_W-1:0] data_out
);

  logic              vld_d, vld_q;
  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    vld_d  = vld_in;
    data_d = vld_in ? data_in : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_out  = vld_q;
  assign data_out = data_q;

endmodule

// File: rtl/sys_feeder.sv
// Feeds one weight tile and a stream of activation rows into the 2x2 systolic array.
// Optional weight reuse (skip weight load) is enabled by defining SYS_FEEDER_REUSE_W_EN.
module sys_feeder
  import sys_feeder_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ROW_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
`ifdef SYS_FEEDER_REUSE_W_EN
  input  logic                   reuse_w_in,
`endif
  input  logic                   w_valid_in,
  output logic                   w_ready_out,
  input  logic [2*DATA_W-1:0]    w_row_in,
  input  logic                   a_valid_in,
  output logic                   a_ready_out,
  input  logic [2*DATA_W-1:0]    a_row_in,
  input  logic                   a_last_in,
  output logic [DATA_W-1:0]      sys_weight_in_x1,
  output logic [DATA_W-1:0]      sys_weight_in_x2,
  output logic                   sys_accept_w_1,
  output logic                   sys_accept_w_2,
  output logic                   sys_switch_in,
  output logic [DATA_W-1:0]      sys_data_in_1x,
  output logic [DATA_W-1:0]      sys_data_in_2x,
  output logic                   sys_start,
  output logic [15:0]            ub_rd_col_size_out,
  output logic                   ub_rd_col_size_valid_out,
  output logic [ROW_CNT_W-1:0]   rows_sent_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam logic [ROW_CNT_W-1:0] ROW_ONE = {{(ROW_CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [ROW_CNT_W-1:0] sat_inc(input logic [ROW_CNT_W-1:0] v);
    return (&v) ? v : v + ROW_ONE;
  endfunction

  sys_feeder_state_t state_d, state_q;
  logic [SYS_COLS-1:0][SYS_COLS-1:0][DATA_W-1:0] wb_d, wb_q;
  logic                 w_cnt_d, w_cnt_q;
  logic                 reuse_d, reuse_q;
  logic                 last_hs_d, last_hs_q;
  logic                 w_ready_d, w_ready_q;
  logic                 a_ready_d, a_ready_q;
  logic [DATA_W-1:0]    x1_d, x1_q, x2_d, x2_q;
  logic                 acc1_d, acc1_q, acc2_d, acc2_q, switch_d, switch_q;
  logic [DATA_W-1:0]    lane1_d, lane1_q, lane2_d, lane2_q;
  logic                 act_vld_d, act_vld_q;
  logic                 col_vld_d, col_vld_q;
  logic [ROW_CNT_W-1:0] rows_d, rows_q;
  logic                 busy_d, busy_q, done_d, done_q;

  logic                 w_hs, a_hs, start_ok, push_en;
  logic                 skew_vld;
  logic [DATA_W-1:0]    skew_data;

  assign w_hs     = w_valid_in & w_ready_q;
  assign a_hs     = a_valid_in & a_ready_q;
  assign start_ok = (state_q == ST_IDLE) & start_in;

  // Lane 2 runs one cycle behind lane 1 through this delay stage.
  sys_skew_reg #(.DATA_W(DATA_W)) u_skew (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (a_hs),
    .data_in  (a_row_in[2*DATA_W-1:DATA_W]),
    .vld_out  (skew_vld),
    .data_out (skew_data)
  );

  always_comb begin
    state_d   = state_q;
    wb_d      = wb_q;
    w_cnt_d   = w_cnt_q;
    reuse_d   = reuse_q;
    rows_d    = rows_q;
    last_hs_d = a_hs & a_last_in;

    if (start_ok) begin
      rows_d  = '0;
      w_cnt_d = 1'b0;
`ifdef SYS_FEEDER_REUSE_W_EN
      reuse_d = reuse_w_in;
`else
      reuse_d = 1'b0;
`endif
    end else if (a_hs) begin
      rows_d = sat_inc(rows_q);
    end

    if (w_hs) begin
      wb_d[w_cnt_q] = w_row_in;
      w_cnt_d       = ~w_cnt_q;
    end

    // DRAIN comes two cycles after the last row is accepted, once lane 2 has it.
    case (state_q)
      ST_IDLE:   if (start_in) state_d = reuse_d ? ST_PUSH1 : ST_W_CAP;
      ST_W_CAP:  if (w_hs && w_cnt_q) state_d = ST_PUSH0;
      ST_PUSH0:  state_d = ST_PUSH1;
      ST_PUSH1,
      ST_STREAM: state_d = last_hs_q ? ST_DRAIN : ST_STREAM;
      ST_DRAIN:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    push_en   = ~reuse_d;
    w_ready_d = (state_d == ST_W_CAP);
    a_ready_d = ((state_d == ST_PUSH0) || (state_d == ST_PUSH1) || (state_d == ST_STREAM))
                && !(a_hs && a_last_in);
    col_vld_d = (state_d != ST_IDLE) && (state_d != ST_W_CAP);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_DRAIN);

    // Rows go in reverse order; column 2 trails column 1 by one cycle.
    acc1_d   = push_en & ((state_d == ST_PUSH0) || (state_d == ST_PUSH1));
    acc2_d   = push_en & ((state_d == ST_PUSH1) || (state_q == ST_PUSH1));
    switch_d = acc2_d;
    x1_d     = x1_q;
    x2_d     = x2_q;
    if (push_en && state_d == ST_PUSH0)      x1_d = wb_d[1][0];
    else if (push_en && state_d == ST_PUSH1) x1_d = wb_d[0][0];
    if (push_en && state_d == ST_PUSH1)      x2_d = wb_d[1][1];
    else if (push_en && state_q == ST_PUSH1) x2_d = wb_d[0][1];

    act_vld_d = a_hs;
    lane1_d   = a_hs ? a_row_in[DATA_W-1:0] : '0;
    lane2_d   = skew_vld ? skew_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wb_q      <= '0;
      w_cnt_q   <= 1'b0;
      reuse_q   <= 1'b0;
      last_hs_q <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      x1_q      <= '0;
      x2_q      <= '0;
      acc1_q    <= 1'b0;
      acc2_q    <= 1'b0;
      switch_q  <= 1'b0;
      lane1_q   <= '0;
      lane2_q   <= '0;
      act_vld_q <= 1'b0;
      col_vld_q <= 1'b0;
      rows_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_q      <= wb_d;
      w_cnt_q   <= w_cnt_d;
      reuse_q   <= reuse_d;
      last_hs_q <= last_hs_d;
      w_ready_q <= w_ready_d;
      a_ready_q <= a_ready_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      switch_q  <= switch_d;
      lane1_q   <= lane1_d;
      lane2_q   <= lane2_d;
      act_vld_q <= act_vld_d;
      col_vld_q <= col_vld_d;
      rows_q    <= rows_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign w_ready_out              = w_ready_q;
  assign a_ready_out              = a_ready_q;
  assign sys_weight_in_x1         = x1_q;
  assign sys_weight_in_x2         = x2_q;
  assign sys_accept_w_1           = acc1_q;
  assign sys_accept_w_2           = acc2_q;
  assign sys_switch_in            = switch_q;
  assign sys_data_in_1x           = lane1_q;
  assign sys_data_in_2x           = lane2_q;
  assign sys_start                = act_vld_q;
  assign ub_rd_col_size_out       = UB_COL_SIZE;
  assign ub_rd_col_size_valid_out = col_vld_q;
  assign rows_sent_out            = rows_q;
  assign busy_out                 = busy_q;
  assign done_out                 = done_q;

endmodule

// File: tb/tb_sys_feeder.sv
// Self-checking bench for sys_feeder: table-driven tile plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_sys_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_in, w_valid_in, a_valid_in, a_last_in;
  logic [31:0] w_row_in, a_row_in;
`ifdef SYS_FEEDER_REUSE_W_EN
  logic        reuse_w_in;
`endif
  logic        w_ready_out, a_ready_out, sys_accept_w_1, sys_accept_w_2, sys_switch_in;
  logic [15:0] sys_weight_in_x1, sys_weight_in_x2, sys_data_in_1x, sys_data_in_2x;
  logic        sys_start, ub_rd_col_size_valid_out, busy_out, done_out;
  logic [15:0] ub_rd_col_size_out, rows_sent_out;

  sys_feeder #(.DATA_W(16), .ROW_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_in(start_in),
`ifdef SYS_FEEDER_REUSE_W_EN
    .reuse_w_in(reuse_w_in),
`endif
    .w_valid_in(w_valid_in), .w_ready_out(w_ready_out), .w_row_in(w_row_in),
    .a_valid_in(a_valid_in), .a_ready_out(a_ready_out), .a_row_in(a_row_in),
    .a_last_in(a_last_in),
    .sys_weight_in_x1(sys_weight_in_x1), .sys_weight_in_x2(sys_weight_in_x2),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in),
    .sys_data_in_1x(sys_data_in_1x), .sys_data_in_2x(sys_data_in_2x),
    .sys_start(sys_start),
    .ub_rd_col_size_out(ub_rd_col_size_out),
    .ub_rd_col_size_valid_out(ub_rd_col_size_valid_out),
    .rows_sent_out(rows_sent_out), .busy_out(busy_out), .done_out(done_out)
  );

  localparam logic [31:0] W0 = {16'h0459, 16'h0100};
  localparam logic [31:0] W1 = {16'h0100, 16'h05C0};
  localparam logic [31:0] A0 = {16'h0200, 16'h01CD};
  localparam logic [31:0] A1 = {16'h0600, 16'h057B};
  localparam logic [31:0] A2 = {16'hED24, 16'hF052};
  localparam logic [31:0] A3 = {16'h0343, 16'h075C};

  // ctrl = {acc1, acc2, switch, w_ready, a_ready, busy, done, col_size_valid}
  typedef struct packed {
    logic        start;
    logic        wv;
    logic [31:0] wrow;
    logic        av;
    logic [31:0] arow;
    logic        alast;
    logic [7:0]  ctrl;
    logic [15:0] x1;
    logic [15:0] x2;
    logic [15:0] rows;
  } vec_t;

  vec_t        tbl [10];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] sb_q [$];
  logic [15:0] exp_lane2 = '0;

  function automatic logic [7:0] ctrl_now();
    return {sys_accept_w_1, sys_accept_w_2, sys_switch_in, w_ready_out, a_ready_out,
            busy_out, done_out, ub_rd_col_size_valid_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    start_in = 1'b0; w_valid_in = 1'b0; w_row_in = '0;
    a_valid_in = 1'b0; a_row_in = '0; a_last_in = 1'b0;
`ifdef SYS_FEEDER_REUSE_W_EN
    reuse_w_in = 1'b0;
`endif
  endtask

  task automatic drive_a(input logic [31:0] row, input logic last);
    a_valid_in = 1'b1; a_row_in = row; a_last_in = last;
  endtask

  // Advance one clock; accepted rows go to the scoreboard and come back out on the lanes.
  task automatic tick();
    logic        hs;
    logic [31:0] e;
    hs = a_valid_in && a_ready_out;
    if (hs) sb_q.push_back(a_row_in);
    @(posedge clk); #1;
    chk("lane2", {16'h0, sys_data_in_2x}, {16'h0, exp_lane2});
    exp_lane2 = '0;
    chk("sys_start", {31'h0, sys_start}, {31'h0, hs});
    if (hs) begin
      e = sb_q.pop_front();
      chk("lane1", {16'h0, sys_data_in_1x}, {16'h0, e[15:0]});
      exp_lane2 = e[31:16];
    end else begin
      chk("lane1_idle", {16'h0, sys_data_in_1x}, 32'h0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {24'h0, ctrl_now()}, 32'h0);
    chk({tag, "_x"}, {sys_weight_in_x2, sys_weight_in_x1}, 32'h0);
    chk({tag, "_lanes"}, {sys_data_in_2x, sys_data_in_1x}, 32'h0);
    chk({tag, "_start_rows"}, {15'h0, sys_start, rows_sent_out}, 32'h0);
    chk({tag, "_colsize"}, {16'h0, ub_rd_col_size_out}, 32'h2);
  endtask

  task automatic load_w();
    start_in = 1'b1; tick();
    start_in = 1'b0; w_valid_in = 1'b1; w_row_in = W0; tick();
    w_row_in = W1; tick();
    set_idle();
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      start_in = tbl[i].start; w_valid_in = tbl[i].wv; w_row_in = tbl[i].wrow;
      a_valid_in = tbl[i].av; a_row_in = tbl[i].arow; a_last_in = tbl[i].alast;
      tick();
      chk($sformatf("%s_ctrl[%0d]", tag, i), {24'h0, ctrl_now()}, {24'h0, tbl[i].ctrl});
      chk($sformatf("%s_x1[%0d]", tag, i), {16'h0, sys_weight_in_x1}, {16'h0, tbl[i].x1});
      chk($sformatf("%s_x2[%0d]", tag, i), {16'h0, sys_weight_in_x2}, {16'h0, tbl[i].x2});
      chk($sformatf("%s_rows[%0d]", tag, i), {16'h0, rows_sent_out}, {16'h0, tbl[i].rows});
    end
    set_idle();
  endtask

  initial begin
    // Full tile: weight capture, push pattern, 4 contiguous rows; start at row 5 is while busy.
    tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'b0001_0100, 16'h0000, 16'h0000, 16'd0};
    tbl[1] = '{1'b0, 1'b1, W0,    1'b0, 32'h0, 1'b0, 8'b0001_0100, 16'h0000, 16'h0000, 16'd0};
    tbl[2] = '{1'b0, 1'b1, W1,    1'b0, 32'h0, 1'b0, 8'b1000_1101, 16'h05C0, 16'h0000, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 32'h0, 1'b1, A0,    1'b0, 8'b1110_1101, 16'h0100, 16'h0100, 16'd1};
    tbl[4] = '{1'b0, 1'b0, 32'h0, 1'b1, A1,    1'b0, 8'b0110_1101, 16'h0100, 16'h0459, 16'd2};
    tbl[5] = '{1'b1, 1'b0, 32'h0, 1'b1, A2,    1'b0, 8'b0000_1101, 16'h0100, 16'h0459, 16'd3};
    tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b1, A3,    1'b1, 8'b0000_0101, 16'h0100, 16'h0459, 16'd4};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'b0000_0101, 16'h0100, 16'h0459, 16'd4};
    tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'b0000_0010, 16'h0100, 16'h0459, 16'd4};
    tbl[9] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'b0000_0000, 16'h0100, 16'h0459, 16'd4};

    rst = 1'b0;
    set_idle();
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run_table("tile");

    // Bubble after row 2: scoreboard checks lane order and the zero slots.
    load_w();
    drive_a(A0, 1'b0); tick();
    drive_a(A1, 1'b0); tick();
    set_idle();        tick();
    drive_a(A2, 1'b0); tick();
    drive_a(A3, 1'b1); tick();
    set_idle();
    chk("bubble_ardy_after_last", {31'h0, a_ready_out}, 32'h0);
    tick();
    chk("bubble_drain", {30'h0, busy_out, done_out}, 32'h2);
    tick();
    chk("bubble_done", {30'h0, busy_out, done_out}, 32'h1);
    chk("bubble_rows", {16'h0, rows_sent_out}, 32'd4);

    // Single-row tile: weight push timing must match the full tile.
    load_w();
    drive_a(A2, 1'b1); tick();
    chk("m1_p1_ctrl", {24'h0, ctrl_now()}, {24'h0, 8'b1110_0101});
    chk("m1_p1_x", {sys_weight_in_x2, sys_weight_in_x1}, {16'h0100, 16'h0100});
    set_idle(); tick();
    chk("m1_drain_ctrl", {24'h0, ctrl_now()}, {24'h0, 8'b0110_0101});
    chk("m1_drain_x", {sys_weight_in_x2, sys_weight_in_x1}, {16'h0459, 16'h0100});
    tick();
    chk("m1_done_ctrl", {24'h0, ctrl_now()}, {24'h0, 8'b0000_0010});
    chk("m1_rows", {16'h0, rows_sent_out}, 32'd1);
    tick();
    chk("m1_done_pulse", {31'h0, done_out}, 32'h0);

    // Asynchronous reset while streaming aborts the tile without done.
    load_w();
    drive_a(A0, 1'b0); tick();
    drive_a(A1, 1'b0); tick();
    drive_a(A2, 1'b0); tick();
    set_idle();
    #3 rst = 1'b0;
    #1 check_zero("async_rst");
    sb_q.delete();
    exp_lane2 = '0;
    @(posedge clk); #1;
    check_zero("rst_held");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_done", {30'h0, busy_out, done_out}, 32'h0);
    end

    run_table("tile2");

`ifdef SYS_FEEDER_REUSE_W_EN
    // Reuse tile: no weight pulses; lane 1 follows the first handshake.
    start_in = 1'b1; reuse_w_in = 1'b1; tick();
    chk("reuse_p1_ctrl", {24'h0, ctrl_now()}, {24'h0, 8'b0000_1101});
    chk("reuse_x_hold", {sys_weight_in_x2, sys_weight_in_x1}, {16'h0459, 16'h0100});
    set_idle();
    start_in = 1'b1; drive_a(A0, 1'b0); tick();
    chk("reuse_s1_ctrl", {24'h0, ctrl_now()}, {24'h0, 8'b0000_1101});
    set_idle();
    drive_a(A1, 1'b1); tick();
    chk("reuse_s2_ctrl", {24'h0, ctrl_now()}, {24'h0, 8'b0000_0101});
    set_idle(); tick();
    chk("reuse_drain_ctrl", {24'h0, ctrl_now()}, {24'h0, 8'b0000_0101});
    tick();
    chk("reuse_done_ctrl", {24'h0, ctrl_now()}, {24'h0, 8'b0000_0010});
    chk("reuse_rows", {16'h0, rows_sent_out}, 32'd2);
`endif

    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sys_feeder.md
Name: sys_feeder

Overview:
- Upstream stage of the 2x2 systolic array.
- Buffers one 2x2 weight tile (Q8.8) and pushes it into the array columns in reverse row order, staggered by one cycle per column, with the matching accept_w/switch controls.
- Then streams activation rows from the unified-buffer read path onto the array's left-edge lanes, with lane 2 skewed one cycle behind lane 1.
- Also drives the array's column-size inputs.

Parameters:
- DATA_W, 16, element width (Q8.8 signed fixed point).
- ROW_CNT_W, 16, width of the activation row counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start_in  in  1  one-cycle pulse: begin a tile; ignored unless IDLE.
- w_valid_in  in  1  weight row valid.
- w_ready_out  out  1  weight row accepted when w_valid_in & w_ready_out.
- w_row_in  in  2*DATA_W  weight row, [DATA_W-1:0] = column 1.
- a_valid_in  in  1  activation row valid.
- a_ready_out  out  1  activation handshake ready.
- a_row_in  in  2*DATA_W  activation row, [DATA_W-1:0] = element for lane 1.
- a_last_in  in  1  marks final activation row.
- sys_weight_in_x1, sys_weight_in_x2  out  DATA_W  weights to array columns 1/2.
- sys_accept_w_1, sys_accept_w_2  out  1  weight-load enables.
- sys_switch_in  out  1  weight switch.
- sys_data_in_1x, sys_data_in_2x  out  DATA_W  activation lanes 1/2.
- sys_start  out  1  lane-1 activation valid.
- ub_rd_col_size_out  out  16  constant 2.
- ub_rd_col_size_valid_out  out  1  column-size valid.
- rows_sent_out  out  ROW_CNT_W  activation rows issued this tile.
- busy_out  out  1  high in any state other than IDLE.
- done_out  out  1  one-cycle pulse on the DRAIN->IDLE transition.

Behaviour:
- All outputs are registered.
- Reset clears every output to 0, except ub_rd_col_size_out, which is constant 2. Reset also clears the weight buffer, state (to IDLE), counters and the lane-2 skew register. Reset mid-tile aborts with no done_out.

FSM states and transitions:
- IDLE: start_in -> W_CAP.
- W_CAP:
  - w_ready_out=1; captures 2 rows in order, Wb[0] then Wb[1].
  - After the 2nd handshake -> PUSH0.
  - ub_rd_col_size_valid_out rises entering PUSH0 and stays high until IDLE.
- PUSH0 (P0):
  - x1=Wb[1][0], acc1=1.
  - a_ready_out=1.
- PUSH1 (P1):
  - x1=Wb[0][0], acc1=1.
  - x2=Wb[1][1], acc2=1, switch=1.
  - Lane 1 shows the row accepted in P0.
- STREAM:
  - First cycle: x2=Wb[0][1], acc2=1, switch=1.
  - Afterwards: acc1, acc2 and switch are 0; weight outputs hold their last values.
- DRAIN: one cycle, see below.

Activation path:
- a_ready_out=1 in PUSH0, PUSH1 and STREAM, until the a_last_in handshake.
- A row accepted in cycle t appears on sys_data_in_1x in t+1 with sys_start=1, and its element 2 appears on sys_data_in_2x in t+2.
- Bubble (no handshake in cycle t): sys_start=0 and lane 1 = 0 in t+1; lane 2 = 0 in t+2.
- a_last handshake -> DRAIN. In DRAIN: sys_start=0, lane 1 = 0, lane 2 carries the last row's element 2. Then -> IDLE with done_out=1.
- M=1 (a_last on the first row) is legal; the weight timing above is unchanged.
- rows_sent_out increments per handshake, saturates at all-ones, and clears on start_in.
- Weights pass bit-exact; no arithmetic is performed.

Optional Feature:
- Macro: SYS_FEEDER_REUSE_W_EN.
- Enabled: adds input reuse_w_in, sampled with start_in. If it is 1, the tile skips W_CAP and the weight-push pattern, goes IDLE -> PUSH1 with all acc/switch signals held 0, and streams activations against the already-loaded array weights.
- Disabled: the port is absent and every tile reloads weights.

Decomposition:
- Shared package (test_utils_pkg style fixed16 types): fixed16_t, vector16_t, state enum sys_feeder_state_t, constant SYS_COLS=2.
- Sub-module sys_skew_reg: a 1-stage data+valid delay used for lane 2. It has no other sub-modules.

Test Plan:
1. W rows {0x0100,0x0459},{0x05C0,0x0100}, then start:
   - Response: P0 x1=0x05C0/acc1; P1 x1=0x0100/acc1, x2=0x0100/acc2/switch; next cycle x2=0x0459/acc2/switch; then all controls 0.
2. A rows {0x01CD,0x0200},{0x057B,0x0600},{0xF052,0xED24},{0x075C,0x0343} contiguous, last on row 4:
   - Lane 1 shows 0x01CD,0x057B,0xF052,0x075C on consecutive cycles with sys_start=1.
   - Lane 2 shows the same rows' element 2 one cycle later.
   - done_out is 1 cycle after DRAIN; rows_sent_out=4.
3. Bubble after row 2:
   - sys_start=0 and lane 1=0 for one cycle; lane 2 is zero one cycle later; order is preserved.
4. M=1:
   - Single row on lane 1 in P1, its lane-2 element in the first STREAM... DRAIN cycle, then done_out; weight pattern identical to test 1.
5. rst low during STREAM:
   - All outputs 0 immediately (async); no done_out; next start_in runs a clean tile.
6. start_in while busy:
   - Ignored; with SYS_FEEDER_REUSE_W_EN and reuse_w_in=1, no acc/switch pulses and lane 1 begins the cycle after the first activation handshake.
